alu_arbiter: RTL

Shares a single `ALU` instance (ops: 1 add, 2 sub, 3 and, 4 or, 5 xor, others → 0) between `NUM_REQ` requesters. Each requester presents operands and an opcode on a valid/ready channel. The arbiter grants one request at a time, latches its operands, executes through the ALU and returns the result on a shared response channel tagged with the requester index. It sits between the issue logic of multiple clients and the ALU datapath.

---
 rtl/alu_arbiter_if.sv | 33 +++
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Request fan-in and shared response channel of alu_arbiter.
// master: requesters and response consumer; slave: the arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_op1;
  logic [NUM_REQ*WIDTH-1:0] req_op2;
  logic [NUM_REQ*4-1:0]     req_opcode;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     busy;

  modport master (
    output req_valid, req_op1, req_op2,
    output req_opcode, rsp_ready,
    input  req_ready, rsp_valid, rsp_id,
    input  rsp_result, busy
  );

  modport slave (
    input  req_valid, req_op1, req_op2,
    input  req_opcode, rsp_ready,
    output req_ready, rsp_valid, rsp_id,
    output rsp_result, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters: grant, execute, respond.
// Define ALU_ARB_RR_EN for round-robin; default is fixed priority.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_any;
  logic             w_gnt;
  logic [ID_W-1:0]  w_gid;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2;
  logic [3:0]       w_opc;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;
  logic [3:0]       r_opc;
  logic [ID_W-1:0]  r_gid;
  logic [WIDTH-1:0] r_result;
  logic [ID_W-1:0]  r_rid;

  assign w_any = |bus.req_valid;
  assign w_gnt = (r_state == S_IDLE) && w_any;

`ifdef ALU_ARB_RR_EN
  logic [ID_W-1:0] r_ptr;

  function automatic logic [ID_W-1:0] rr_idx(
    input logic [ID_W-1:0] p,
    input int              k
  );
    return ID_W'((int'(p) + k) % NUM_REQ);
  endfunction

  // Descending scan so the nearest index after the pointer wins.
  always_comb begin
    w_gid = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[rr_idx(r_ptr, k)])
        w_gid = rr_idx(r_ptr, k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ptr <= ID_W'(NUM_REQ - 1);
    else if (w_gnt)
      r_ptr <= w_gid;
  end
`else
  always_comb begin
    w_gid = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[ID_W'(k)])
        w_gid = ID_W'(k);
    end
  end
`endif

  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    w_opc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gid == ID_W'(i)) begin
        w_op1 = bus.req_op1[i*WIDTH +: WIDTH];
        w_op2 = bus.req_op2[i*WIDTH +: WIDTH];
        w_opc = bus.req_opcode[i*4 +: 4];
      end
    end
  end

  always_comb begin
    w_alu = '0;
    case (r_opc)
      4'd1:    w_alu = r_op1 + r_op2;
      4'd2:    w_alu = r_op1 - r_op2;
      4'd3:    w_alu = r_op1 & r_op2;
      4'd4:    w_alu = r_op1 | r_op2;
      4'd5:    w_alu = r_op1 ^ r_op2;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1    <= '0;
      r_op2    <= '0;
      r_opc    <= '0;
      r_gid    <= '0;
      r_result <= '0;
      r_rid    <= '0;
    end else begin
      if (w_gnt) begin
        r_op1 <= w_op1;
        r_op2 <= w_op2;
        r_opc <= w_opc;
        r_gid <= w_gid;
      end
      if (r_state == S_EXEC) begin
        r_result <= w_alu;
        r_rid    <= r_gid;
      end
    end
  end

  assign bus.req_ready  = w_gnt ? (NUM_REQ'(1) << w_gid) : '0;
  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.rsp_id     = r_rid;
  assign bus.rsp_result = r_result;
  assign bus.busy       = (r_state != S_IDLE);
endmodule
